alu_sequencer: RTL and testbench

Command-driven controller that owns one 8-bit ALU and a small register file. It accepts one command at a time over a valid/ready handshake and reads two source registers into the ALU operand ports. It then captures the ALU result, writes it back to a destination register and returns the result over a valid/ready response channel. It sits between the project's command source (testbench or upstream control) and the combinational ALU, which is instantiated outside this block and connected through the `alu_*` ports.

---
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven controller around an external 8-bit ALU.
// Reads two registers into the ALU, writes back the result, returns it.
module alu_sequencer #(
  parameter  int NREG = 4,
  localparam int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [IW-1:0] cmd_dst,
  input  logic [IW-1:0] cmd_sa,
  input  logic [IW-1:0] cmd_sb,
  input  logic [7:0]    cmd_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic          rsp_err,
  output logic [3:0]    alu_op,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  input  logic [7:0]    alu_z
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]    r_op;
  logic [IW-1:0] r_dst;
  logic [IW-1:0] r_sa;
  logic [IW-1:0] r_sb;
  logic [7:0]    r_imm;
  logic [7:0]    r_rf [NREG];
  logic          r_cmd_ready;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_data;
  logic          r_rsp_err;
  logic [3:0]    r_alu_op;
  logic [7:0]    r_alu_a;
  logic [7:0]    r_alu_b;

  logic       w_accept;
  logic       w_done;
  logic       w_loadi;
  logic       w_illegal;
  logic [7:0] w_result;

  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_done    = r_rsp_valid && rsp_ready;
  assign w_loadi   = (r_op == 4'hF);
  assign w_illegal = (r_op >= 4'hA) && !w_loadi;

  always_comb begin
    w_result = alu_z;
    unique case (1'b1)
      w_loadi:   w_result = r_imm;
      w_illegal: w_result = 8'h00;
      default:   w_result = alu_z;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_READ;
      S_READ: w_next = S_EXEC;
      S_EXEC: w_next = S_RESP;
      S_RESP: if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // cmd_ready is a registered image of "next state is IDLE"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_dst       <= '0;
      r_sa        <= '0;
      r_sb        <= '0;
      r_imm       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      r_cmd_ready <= (w_next == S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= cmd_op;
            r_dst <= cmd_dst;
            r_sa  <= cmd_sa;
            r_sb  <= cmd_sb;
            r_imm <= cmd_imm;
          end
        end
        S_READ: begin
          r_alu_op <= r_op;
          r_alu_a  <= r_rf[r_sa];
          r_alu_b  <= r_rf[r_sb];
        end
        S_EXEC: begin
          r_rsp_data  <= w_result;
          r_rsp_err   <= w_illegal;
          r_rsp_valid <= 1'b1;
          if (!w_illegal) r_rf[r_dst] <= w_result;
        end
        S_RESP: begin
          if (w_done) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors, external ALU model and a
// transaction-level reference model checked every cycle.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_sa;
  logic [1:0] cmd_sb;
  logic [7:0] cmd_imm;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_z;

  int n_vec = 0;
  int n_err = 0;

  alu_sequencer #(.NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst),
    .cmd_sa(cmd_sa), .cmd_sb(cmd_sb), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(logic [3:0] op, logic [7:0] a,
                                        logic [7:0] b);
    case (op)
      4'h0: return 8'h00;
      4'h1: return 8'h01;
      4'h2: return a;
      4'h3: return b;
      4'h4: return a + b;
      4'h5: return 8'h00 - a;
      4'h6: return a & b;
      4'h7: return a | b;
      4'h8: return (a == b) ? 8'h01 : 8'h00;
      4'h9: return (a > b) ? 8'h01 : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_z = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Reference model: a command's response is due two edges after accept
  logic [7:0] m_reg [4];
  logic       m_rdy, m_rv, m_busy, m_re, m_pe, m_pw;
  logic [7:0] m_rd, m_pd;
  logic [1:0] m_pdst;
  int         m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_reg[i] <= 8'h00;
      m_rdy  <= 1'b0;
      m_rv   <= 1'b0;
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (m_rdy && cmd_valid) begin
      m_rdy  <= 1'b0;
      m_busy <= 1'b1;
      m_age  <= 1;
      m_pdst <= cmd_dst;
      if (cmd_op == 4'hF) begin
        m_pd <= cmd_imm; m_pe <= 1'b0; m_pw <= 1'b1;
      end else if (cmd_op >= 4'hA) begin
        m_pd <= 8'h00; m_pe <= 1'b1; m_pw <= 1'b0;
      end else begin
        m_pd <= alu_fn(cmd_op, m_reg[cmd_sa], m_reg[cmd_sb]);
        m_pe <= 1'b0; m_pw <= 1'b1;
      end
    end else if (m_busy && !m_rv) begin
      m_age <= m_age + 1;
      if (m_age == 2) begin
        m_rv <= 1'b1;
        m_rd <= m_pd;
        m_re <= m_pe;
        if (m_pw) m_reg[m_pdst] <= m_pd;
      end
    end else if (m_rv && rsp_ready) begin
      m_rv   <= 1'b0;
      m_busy <= 1'b0;
      m_rdy  <= 1'b1;
    end else if (!m_busy) begin
      m_rdy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_rdy});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
    chk("ready_valid_excl", {31'd0, cmd_ready & rsp_valid}, 32'd0);
    if (m_rv) begin
      chk("rsp_data", {24'd0, rsp_data}, {24'd0, m_rd});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_re});
    end
  end

  task automatic issue(logic [3:0] op, logic [1:0] dst, logic [1:0] sa,
                       logic [1:0] sb, logic [7:0] imm);
    int n;
    cmd_op = op; cmd_dst = dst; cmd_sa = sa; cmd_sb = sb; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [7:0] d, output logic e);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 2);
    d = rsp_data;
    e = rsp_err;
  endtask

  task automatic send(logic [3:0] op, logic [1:0] dst, logic [1:0] sa,
                      logic [1:0] sb, logic [7:0] imm,
                      output logic [7:0] d, output logic e);
    issue(op, dst, sa, sb, imm);
    wait_rsp(d, e);
    @(negedge clk);
  endtask

  logic [7:0] d;
  logic       e;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 4'h2; cmd_dst = 0; cmd_sa = 0; cmd_sb = 0; cmd_imm = 0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      send(4'h2, 2'(i), 2'(i), 2'(i), 8'h00, d, e);
      chk("reset_reg_read", {24'd0, d}, 32'h00);
    end

    send(4'hF, 2'd1, 2'd0, 2'd0, 8'h80, d, e);
    chk("loadi_80", {24'd0, d}, 32'h80);
    send(4'h4, 2'd2, 2'd1, 2'd1, 8'h00, d, e);
    chk("add_wrap", {24'd0, d}, 32'h00);
    chk("add_wrap_err", {31'd0, e}, 32'd0);
    send(4'hF, 2'd3, 2'd0, 2'd0, 8'h01, d, e);
    send(4'h5, 2'd0, 2'd3, 2'd0, 8'h00, d, e);
    chk("neg_01", {24'd0, d}, 32'hFF);

    send(4'hF, 2'd1, 2'd0, 2'd0, 8'h05, d, e);
    send(4'hF, 2'd2, 2'd0, 2'd0, 8'h03, d, e);
    send(4'h9, 2'd0, 2'd1, 2'd2, 8'h00, d, e);
    chk("gt_5_3", {24'd0, d}, 32'h01);
    send(4'h9, 2'd0, 2'd2, 2'd1, 8'h00, d, e);
    chk("gt_3_5", {24'd0, d}, 32'h00);
    send(4'h8, 2'd3, 2'd1, 2'd1, 8'h00, d, e);
    chk("eq_same", {24'd0, d}, 32'h01);
    send(4'h6, 2'd0, 2'd1, 2'd2, 8'h00, d, e);
    chk("and_5_3", {24'd0, d}, 32'h01);
    send(4'h7, 2'd0, 2'd1, 2'd2, 8'h00, d, e);
    chk("or_5_3", {24'd0, d}, 32'h07);
    send(4'h3, 2'd3, 2'd0, 2'd2, 8'h00, d, e);
    chk("op_b", {24'd0, d}, 32'h03);
    send(4'h1, 2'd3, 2'd0, 2'd0, 8'h00, d, e);
    chk("op_one", {24'd0, d}, 32'h01);

    send(4'hF, 2'd2, 2'd0, 2'd0, 8'h3C, d, e);
    send(4'hC, 2'd2, 2'd1, 2'd1, 8'h55, d, e);
    chk("illegal_data", {24'd0, d}, 32'h00);
    chk("illegal_err", {31'd0, e}, 32'd1);
    send(4'h2, 2'd3, 2'd2, 2'd0, 8'h00, d, e);
    chk("no_write_illegal", {24'd0, d}, 32'h3C);

    send(4'h4, 2'd1, 2'd1, 2'd1, 8'h00, d, e);
    chk("self_add", {24'd0, d}, 32'h0A);
    send(4'h2, 2'd0, 2'd1, 2'd0, 8'h00, d, e);
    chk("self_add_wb", {24'd0, d}, 32'h0A);

    rsp_ready = 1'b0;
    issue(4'h4, 2'd3, 2'd1, 2'd2, 8'h00);
    wait_rsp(d, e);
    chk("bp_first", {24'd0, d}, 32'h3C + 32'h0A);
    for (int k = 0; k < 5; k++) begin
      cmd_valid = (k % 2 == 0);
      cmd_op = 4'(k + 1);
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", {24'd0, rsp_data}, 32'h46);
      chk("bp_err", {31'd0, rsp_err}, 32'd0);
      chk("bp_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, cmd_ready}, 32'd1);

    issue(4'hF, 2'd0, 2'd0, 2'd0, 8'hAA);
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    send(4'h2, 2'd1, 2'd0, 2'd0, 8'h00, d, e);
    chk("midrst_r0", {24'd0, d}, 32'h00);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
